// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control types: state encodings, counter widths and the enable-count type.
// Used by cpu_run_ctrl (optional breakpoint build: RUN_CTRL_BREAK_EN).
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } run_state_e;

    typedef logic [31:0] count_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DIV_MAX_DEF       = 65536;
    localparam int unsigned DEBOUNCE_DEF      = 16;
    localparam int unsigned RST_HOLD_DEF      = 4;
    localparam int unsigned DIV_W_DEF         = cnt_width(DIV_MAX_DEF);
    localparam int unsigned HOLD_W_DEF        = cnt_width(RST_HOLD_DEF);

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Two-flop synchronizer, debounce counter and one-cycle press pulse for a single input.
// ACTIVE selects the level that counts as "pressed"; the idle level is the reset value.
module key_debounce
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        ACTIVE          = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic stable_o,
    output logic press_o
);

    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = (sync2_q == ACTIVE);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q  <= ~ACTIVE;
            sync2_q  <= ~ACTIVE;
            stable_q <= ~ACTIVE;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign press_o  = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run-control sequencer: clock-enable divider, debounced keys, reset/run/halt/step FSM.
// Define RUN_CTRL_BREAK_EN to add a single PC breakpoint that halts free-run.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned DIV_MAX         = 65536,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RST_HOLD_TICKS  = 4
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [1:0]  key_n,
    input  logic        sw_run,
    input  logic        cpu_halted,
`ifdef RUN_CTRL_BREAK_EN
    input  logic [31:0] cpu_pc,
    input  logic [31:0] bp_addr,
    input  logic [0:0]  bp_valid,
`endif
    output logic        cpu_clk_en,
    output logic        cpu_reset,
    output logic [1:0]  run_state,
    output logic [31:0] enable_count
);

    localparam int unsigned   DW        = cnt_width(DIV_MAX);
    localparam int unsigned   HW        = cnt_width(RST_HOLD_TICKS);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_TICKS - 1);

    run_state_e    state_q;
    run_state_e    state_d;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick_q;
    logic          tick_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    count_t        count_q;
    count_t        count_d;
    logic          clk_en;
    logic          bp_hit;

    logic key0_press;
    logic key1_press;
    logic sw_stable;
    logic sw_rise;
    logic key0_stable;
    logic key1_stable;
    logic unused_stable;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE(1'b0)) u_key0 (
        .clk_i    (clock_in),
        .rst_i    (reset_in),
        .raw_i    (key_n[0]),
        .stable_o (key0_stable),
        .press_o  (key0_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE(1'b0)) u_key1 (
        .clk_i    (clock_in),
        .rst_i    (reset_in),
        .raw_i    (key_n[1]),
        .stable_o (key1_stable),
        .press_o  (key1_press)
    );

    // Active-high instance: its press pulse is the debounced 0->1 edge of the switch.
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .ACTIVE(1'b1)) u_sw (
        .clk_i    (clock_in),
        .rst_i    (reset_in),
        .raw_i    (sw_run),
        .stable_o (sw_stable),
        .press_o  (sw_rise)
    );

    assign unused_stable = key0_stable ^ key1_stable;

    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        tick_d = (div_q == DIV_LAST);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clk_en  = 1'b0;
        bp_hit  = 1'b0;
`ifdef RUN_CTRL_BREAK_EN
        bp_hit  = bp_valid[0] && (cpu_pc == bp_addr);
`endif
        case (state_q)
            ST_RESET: begin
                clk_en = tick_q;
                if (tick_q) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = sw_stable ? ST_RUN : ST_HALT;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            ST_RUN: begin
                clk_en = tick_q && !bp_hit;
                if (key1_press || !sw_stable || cpu_halted || (tick_q && bp_hit)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (key1_press) begin
                    state_d = ST_STEP;
                end else if (sw_rise && !cpu_halted) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                clk_en = tick_q;
                if (tick_q) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_RESET;
        endcase
        if (key0_press) begin
            state_d = ST_RESET;
            hold_d  = '0;
        end
    end

    // Enables issued while the core is held in reset are not counted.
    always_comb begin
        count_d = count_q;
        if (key0_press || state_q == ST_RESET) begin
            count_d = '0;
        end else if (clk_en) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= ST_RESET;
            div_q   <= '0;
            tick_q  <= 1'b0;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    assign cpu_clk_en   = clk_en;
    assign cpu_reset    = (state_q == ST_RESET);
    assign run_state    = state_q;
    assign enable_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl with DIV_MAX=4, DEBOUNCE_CYCLES=4, RST_HOLD_TICKS=2.
// Stimulus queues the expected state/reset/count for every enable; a monitor checks each enable.
module tb_cpu_run_ctrl;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;
    localparam logic [1:0] S_STEP  = 2'd3;

    typedef struct packed {
        logic [1:0]  st;
        logic        rst;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset_in;
    logic [1:0]  key_n;
    logic        sw_run;
    logic        cpu_halted;
    logic        cpu_clk_en;
    logic        cpu_reset;
    logic [1:0]  run_state;
    logic [31:0] enable_count;
`ifdef RUN_CTRL_BREAK_EN
    logic [31:0] cpu_pc;
    logic [31:0] bp_addr;
    logic [0:0]  bp_valid;
`endif

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_errs  = 0;
    int   n_en    = 0;

    cpu_run_ctrl #(.DIV_MAX(4), .DEBOUNCE_CYCLES(4), .RST_HOLD_TICKS(2)) dut (
        .clock_in     (clk),
        .reset_in     (reset_in),
        .key_n        (key_n),
        .sw_run       (sw_run),
        .cpu_halted   (cpu_halted),
`ifdef RUN_CTRL_BREAK_EN
        .cpu_pc       (cpu_pc),
        .bp_addr      (bp_addr),
        .bp_valid     (bp_valid),
`endif
        .cpu_clk_en   (cpu_clk_en),
        .cpu_reset    (cpu_reset),
        .run_state    (run_state),
        .enable_count (enable_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Monitor: every enable the DUT presents must match the oldest queued expectation.
    initial begin
        exp_t got;
        exp_t exp;
        forever begin
            @(negedge clk);
            if (cpu_clk_en === 1'b1) begin
                n_en++;
                n_tests++;
                got = {run_state, cpu_reset, enable_count};
                if (sb_q.size() == 0) begin
                    n_errs++;
                    $display("FAIL unexpected_enable_%0d: got state=%0d rst=%0b count=%0d, required no enable",
                             n_en, got.st, got.rst, got.cnt);
                end else begin
                    exp = sb_q.pop_front();
                    if (got !== exp) begin
                        n_errs++;
                        $display("FAIL enable_%0d: got state=%0d rst=%0b count=%0d, required state=%0d rst=%0b count=%0d",
                                 n_en, got.st, got.rst, got.cnt, exp.st, exp.rst, exp.cnt);
                    end
                end
            end
        end
    end

    task automatic push(input logic [1:0] st, input logic rst, input logic [31:0] cnt);
        exp_t e;
        e.st  = st;
        e.rst = rst;
        e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_en(input int target, input string name);
        int budget;
        budget = 200;
        while (n_en < target && budget > 0) begin
            @(negedge clk);
            #1;
            budget--;
        end
        check({name, "_enable_seen"}, 32'(n_en >= target), 32'd1);
    endtask

    task automatic step_once(input logic [31:0] cnt, input string name);
        int target;
        target = n_en + 1;
        push(S_STEP, 1'b0, cnt);
        key_n[1] = 1'b0;
        wait_en(target, name);
        key_n[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check({name, "_state"}, 32'(run_state), 32'(S_HALT));
        check({name, "_count"}, enable_count, cnt + 32'd1);
    endtask

    initial begin
        reset_in   = 1'b1;
        key_n      = 2'b11;
        sw_run     = 1'b1;
        cpu_halted = 1'b0;
`ifdef RUN_CTRL_BREAK_EN
        cpu_pc     = 32'h0;
        bp_addr    = 32'h10;
        bp_valid   = 1'b1;
`endif
        @(posedge clk);
        #1;
        check("rst_state", 32'(run_state), 32'(S_RESET));
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_clk_en", 32'(cpu_clk_en), 32'd0);
        check("rst_count", enable_count, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // Release: two clocked-reset enables, then free-run.
        push(S_RESET, 1'b1, 32'd0);
        push(S_RESET, 1'b1, 32'd0);
        push(S_RUN, 1'b0, 32'd0);
        push(S_RUN, 1'b0, 32'd1);
        push(S_RUN, 1'b0, 32'd2);
        reset_in = 1'b0;
        wait_en(5, "boot");
        check("boot_state", 32'(run_state), 32'(S_RUN));
        check("boot_cpu_reset", 32'(cpu_reset), 32'd0);

        // Three-cycle glitch on key1 is rejected.
        push(S_RUN, 1'b0, 32'd3);
        key_n[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        key_n[1] = 1'b1;
        wait_en(6, "glitch");
        check("glitch_state", 32'(run_state), 32'(S_RUN));
        check("glitch_count", enable_count, 32'd3);

        // Solid key1 press: one more run enable, then HALT.
        push(S_RUN, 1'b0, 32'd4);
        key_n[1] = 1'b0;
        wait_en(7, "press");
        repeat (4) @(posedge clk);
        #1;
        check("press_state", 32'(run_state), 32'(S_HALT));
        key_n[1] = 1'b1;
        sw_run   = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("press_single", 32'(run_state), 32'(S_HALT));
        check("press_count", enable_count, 32'd5);

        step_once(32'd5, "step1");
        step_once(32'd6, "step2");
        step_once(32'd7, "step3");

        // Back to RUN, then cpu_halted raised during a tick cycle.
        push(S_RUN, 1'b0, 32'd8);
        sw_run = 1'b1;
        wait_en(n_en + 1, "resume");
        check("resume_state", 32'(run_state), 32'(S_RUN));
        push(S_RUN, 1'b0, 32'd9);
        repeat (4) @(posedge clk);
        #1;
        cpu_halted = 1'b1;
        wait_en(n_en + 1, "halted_tick");
        @(posedge clk);
        #1;
        check("halted_state", 32'(run_state), 32'(S_HALT));
        check("halted_count", enable_count, 32'd10);
        sw_run = 1'b0;
        repeat (10) @(posedge clk);
        sw_run = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("halted_no_resume", 32'(run_state), 32'(S_HALT));
        sw_run = 1'b0;
        repeat (10) @(posedge clk);

        // Step while cpu_halted, used as a phase reference for the key0-in-STEP case.
        push(S_STEP, 1'b0, 32'd10);
        key_n[1] = 1'b0;
        wait_en(n_en + 1, "sync_step");
        key_n[1] = 1'b1;
        repeat (7) @(negedge clk);
        key_n[1] = 1'b0;
        @(negedge clk);
        key_n[0] = 1'b0;
        push(S_RESET, 1'b1, 32'd0);
        push(S_RESET, 1'b1, 32'd0);
        repeat (6) @(negedge clk);
        check("key0_in_step", 32'(run_state), 32'(S_STEP));
        @(negedge clk);
        check("key0_state", 32'(run_state), 32'(S_RESET));
        check("key0_cpu_reset", 32'(cpu_reset), 32'd1);
        check("key0_count", enable_count, 32'd0);
        key_n = 2'b11;
        wait_en(n_en + 2, "key0_hold");
        @(posedge clk);
        #1;
        check("key0_exit_state", 32'(run_state), 32'(S_HALT));
        check("key0_exit_cpu_reset", 32'(cpu_reset), 32'd0);

        // reset_in asserted in the middle of RUN.
        cpu_halted = 1'b0;
        push(S_RUN, 1'b0, 32'd0);
        sw_run = 1'b1;
        wait_en(n_en + 1, "rerun");
        @(posedge clk);
        #1;
        reset_in = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_state", 32'(run_state), 32'(S_RESET));
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_clk_en", 32'(cpu_clk_en), 32'd0);
        check("midrst_count", enable_count, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        push(S_RESET, 1'b1, 32'd0);
        push(S_RESET, 1'b1, 32'd0);
        push(S_RUN, 1'b0, 32'd0);
        reset_in = 1'b0;
        wait_en(n_en + 3, "reboot");

`ifdef RUN_CTRL_BREAK_EN
        cpu_pc = 32'h10;
        repeat (6) @(posedge clk);
        #1;
        check("bp_state", 32'(run_state), 32'(S_HALT));
        check("bp_count", enable_count, 32'd1);
        step_once(32'd1, "bp_step");
`endif

        reset_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_errs);
        $finish;
    end

endmodule
